// File: rtl/aes_key_schedule_multi.sv
// rtl/aes_key_schedule_multi.sv - AES-128/192/256 key expansion, one word per clock; optional AES_KEYSCHED_INV_EN adds InvMixColumns readout
module aes_key_schedule_multi #(
    parameter int MAX_NK     = 8,
    parameter bit RK_REG_OUT = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [1:0]   i_key_size,
    input  logic [255:0] i_key_in,
`ifdef AES_KEYSCHED_INV_EN
    input  logic         i_inv_rk,
`endif
    input  logic [3:0]   i_rk_addr,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ready,
    output logic         o_err,
    output logic [127:0] o_rk_out
);

    localparam int NW_MAX = 4 * (MAX_NK + 7);
    localparam int AW     = $clog2(NW_MAX);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_w [0:NW_MAX-1];
    logic [3:0]     r_nk;
    logic [3:0]     r_nr;
    logic [AW-1:0]  r_last;
    logic [AW-1:0]  r_i;
    logic [2:0]     r_j;
    logic [7:0]     r_rcon;
    logic           r_ready;
    logic           r_err;

    logic [3:0]     w_nk;
    logic           w_key_ok;
    logic           w_accept;
    logic           w_reject;
    logic [AW-1:0]  w_last;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub;
    logic [31:0]    w_t;
    logic [31:0]    w_new;
    logic [AW-1:0]  w_rk_base;
    logic           w_rk_hit;
    logic [127:0]   w_rk_raw;
    logic [127:0]   w_rk_val;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform; avoids a 256-entry table
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] iv;
        sq = a;
        iv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            iv = gf_mul(iv, sq);
        end
        return iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                  ^ {iv[3:0], iv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

`ifdef AES_KEYSCHED_INV_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction
`endif

    // Decode key size; reserved code or a key longer than storage allows is rejected
    always_comb begin
        w_nk     = 4'd4;
        w_key_ok = 1'b1;
        case (i_key_size)
            2'b00:   w_nk = 4'd4;
            2'b01:   w_nk = 4'd6;
            2'b10:   w_nk = 4'd8;
            default: begin
                w_nk     = 4'd0;
                w_key_ok = 1'b0;
            end
        endcase
        if (32'(w_nk) > MAX_NK) w_key_ok = 1'b0;
    end

    assign w_accept = (r_state == S_IDLE) && i_start && w_key_ok;
    assign w_reject = (r_state == S_IDLE) && i_start && !w_key_ok;
    // Index of the last schedule word: Nw-1 = 4*Nk+27
    assign w_last   = AW'({w_nk, 2'b00}) + AW'(27);

    // Next-word datapath; the single SubWord unit serves both the RotWord and the Nk=8 mid-block case
    assign w_prev   = r_w[r_i - AW'(1)];
    assign w_back   = r_w[r_i - AW'(r_nk)];
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign w_sub    = sub_word(w_sub_in);

    // Select the temp word t for the current position within the Nk-word block
    always_comb begin
        w_t = w_prev;
        if (r_j == 3'd0)
            w_t = w_sub ^ {r_rcon, 24'h0};
        else if ((r_nk == 4'd8) && (r_j == 3'd4))
            w_t = w_sub;
    end

    assign w_new = w_back ^ w_t;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_EXPAND;
            S_EXPAND: if (r_i == r_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (r_state == S_EXPAND);
        o_done = (r_state == S_DONE);
    end

    assign o_ready = r_ready;
    assign o_err   = r_err;

    // Expansion counters, rcon, and the ready/err status flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nk    <= 4'd0;
            r_nr    <= 4'd0;
            r_last  <= '0;
            r_i     <= '0;
            r_j     <= 3'd0;
            r_rcon  <= 8'h00;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_nk    <= w_nk;
            r_nr    <= w_nk + 4'd6;
            r_last  <= w_last;
            r_i     <= AW'(w_nk);
            r_j     <= 3'd0;
            r_rcon  <= 8'h01;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_reject) begin
            r_err   <= 1'b1;
            r_ready <= 1'b0;
        end else if (r_state == S_EXPAND) begin
            if (r_j == 3'd0)
                r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            if ({1'b0, r_j} == r_nk - 4'd1) r_j <= 3'd0;
            else                            r_j <= r_j + 3'd1;
            r_i <= r_i + AW'(1);
            if (r_i == r_last) r_ready <= 1'b1;
        end
    end

    // Word storage: key words on accept, one expanded word per EXPAND cycle; never reset
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (4'(k) < w_nk) r_w[AW'(k)] <= i_key_in[32*k +: 32];
            end
        end else if (r_state == S_EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    // Round-key read: four consecutive words, zero when no valid schedule or index beyond Nr
    assign w_rk_base = AW'({i_rk_addr, 2'b00});
    assign w_rk_hit  = r_ready && (i_rk_addr <= r_nr);
    assign w_rk_raw  = w_rk_hit ? {r_w[w_rk_base + AW'(3)], r_w[w_rk_base + AW'(2)],
                                   r_w[w_rk_base + AW'(1)], r_w[w_rk_base]} : '0;

`ifdef AES_KEYSCHED_INV_EN
    // Equivalent-inverse-cipher keys for the middle rounds; first and last keys pass through
    always_comb begin
        w_rk_val = w_rk_raw;
        if (i_inv_rk && (i_rk_addr != 4'd0) && (i_rk_addr < r_nr))
            w_rk_val = {inv_mix_word(w_rk_raw[127:96]), inv_mix_word(w_rk_raw[95:64]),
                        inv_mix_word(w_rk_raw[63:32]), inv_mix_word(w_rk_raw[31:0])};
    end
`else
    assign w_rk_val = w_rk_raw;
`endif

    generate
        if (RK_REG_OUT) begin : g_rk_reg
            logic [127:0] r_rk_out;
            // Registered readout: one cycle of latency from i_rk_addr
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) r_rk_out <= '0;
                else       r_rk_out <= w_rk_val;
            end
            assign o_rk_out = r_rk_out;
        end else begin : g_rk_comb
            assign o_rk_out = w_rk_val;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// tb/tb_aes_key_schedule_multi.sv - scoreboard bench for aes_key_schedule_multi with FIPS-197 vectors
module tb_aes_key_schedule_multi;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   ks = 2'b00;
    logic [255:0] key = '0;
    logic         inv_rk = 1'b0;
    logic [3:0]   rk_addr = 4'd0;
    logic         busy, done, ready, err;
    logic [127:0] rk_out;

    localparam logic [255:0] K128 = {128'h0, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
    localparam logic [255:0] K192 = {64'h0, 32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                     32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
    localparam logic [255:0] K256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                     32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
    localparam logic [127:0] R128_0  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] R128_1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    localparam logic [127:0] R128_5  = 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
    localparam logic [127:0] R128_10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
    localparam logic [127:0] R192_0  = 128'h809079e5_c810f32b_da0e6452_8e73b0f7;
    localparam logic [127:0] R192_1  = 128'h2402f5a5_fe0c91f7_522c6b7b_62f8ead2;
    localparam logic [127:0] R192_12 = {32'h01002202, 96'h0};
    localparam logic [127:0] R256_0  = 128'h857d7781_2b73aef0_15ca71be_603deb10;
    localparam logic [127:0] R256_1  = 128'h0914dff4_2d9810a3_3b6108d7_1f352c07;
    localparam logic [127:0] R256_14 = {32'h706c631e, 96'h0};
    localparam logic [127:0] M_ALL   = {128{1'b1}};
    localparam logic [127:0] M_W3    = {32'hffffffff, 96'h0};

    aes_key_schedule_multi dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_key_size (ks),
        .i_key_in   (key),
`ifdef AES_KEYSCHED_INV_EN
        .i_inv_rk   (inv_rk),
`endif
        .i_rk_addr  (rk_addr),
        .o_busy     (busy),
        .o_done     (done),
        .o_ready    (ready),
        .o_err      (err),
        .o_rk_out   (rk_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;

    logic [127:0] q_val [$];
    logic [127:0] q_mask [$];
    int           q_tag [$];
    bit           q_mix [$];
    int           q_done [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_req_d <= rd_req;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] x);
        return {mixw(x[127:96]), mixw(x[95:64]), mixw(x[63:32]), mixw(x[31:0])};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Monitor: compares every presented read result and every done pulse against the scoreboard
    logic [127:0] m_val, m_mask, m_got;
    int           m_tag;
    bit           m_mix;
    always @(negedge clk) begin
        if (rd_req_d) begin
            if (q_val.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected: got %h want no read", rk_out);
            end else begin
                m_val  = q_val.pop_front();
                m_mask = q_mask.pop_front();
                m_tag  = q_tag.pop_front();
                m_mix  = q_mix.pop_front();
                m_got  = m_mix ? mixcols(rk_out) : rk_out;
                chk($sformatf("rk_t%0d", m_tag), m_got & m_mask, m_val & m_mask);
            end
        end
        if (done) begin
            if (q_done.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_unexpected: got done at cycle %0d want none", cyc);
            end else begin
                chk("done_cycle", 128'(cyc), 128'(q_done.pop_front()));
                chk1("ready_at_done", ready, 1'b1);
                chk1("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic do_start(input logic [1:0] k_sz, input logic [255:0] k, input int lat);
        ks = k_sz;
        key = k;
        start = 1'b1;
        if (lat > 0) q_done.push_back(cyc + lat);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [127:0] e, input logic [127:0] m,
                      input int tag, input bit mx);
        rk_addr = a;
        rd_req = 1'b1;
        q_val.push_back(e);
        q_mask.push_back(m);
        q_tag.push_back(tag);
        q_mix.push_back(mx);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk1("done_seen", seen, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_rk", rk_out, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // reserved key size: rejected, error flagged, nothing starts
        do_start(2'b11, K128, 0);
        chk1("rsv_err", err, 1'b1);
        chk1("rsv_busy", busy, 1'b0);
        chk1("rsv_ready", ready, 1'b0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk1("rsv_busy_hold", busy, 1'b0);
        end
        rd(4'd0, 128'h0, M_ALL, 1, 1'b0);

        // AES-128 with a start pulse during expansion that must be ignored
        do_start(2'b00, K128, 41);
        chk1("acc_err_clr", err, 1'b0);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_ready", ready, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        ks = 2'b10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(80);
        rd(4'd0,  R128_0,  M_ALL, 10, 1'b0);
        rd(4'd1,  R128_1,  M_ALL, 11, 1'b0);
        rd(4'd5,  R128_5,  M_ALL, 15, 1'b0);
        rd(4'd10, R128_10, M_ALL, 20, 1'b0);
        rd(4'd11, 128'h0,  M_ALL, 21, 1'b0);

        // AES-192
        do_start(2'b01, K192, 47);
        wait_done(80);
        rd(4'd0,  R192_0,  M_ALL, 30, 1'b0);
        rd(4'd1,  R192_1,  M_ALL, 31, 1'b0);
        rd(4'd12, R192_12, M_W3,  42, 1'b0);
        rd(4'd13, 128'h0,  M_ALL, 43, 1'b0);

        // AES-256
        do_start(2'b10, K256, 53);
        wait_done(80);
        rd(4'd0,  R256_0,  M_ALL, 50, 1'b0);
        rd(4'd1,  R256_1,  M_ALL, 51, 1'b0);
        rd(4'd14, R256_14, M_W3,  64, 1'b0);
        rd(4'd15, 128'h0,  M_ALL, 65, 1'b0);

        // reset in the middle of an AES-256 expansion
        do_start(2'b10, K256, 0);
        repeat (19) @(posedge clk);
        #1;
        chk1("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready", ready, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        chk("mid_rst_rk", rk_out, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(2'b00, K128, 41);
        wait_done(80);
        rd(4'd10, R128_10, M_ALL, 70, 1'b0);
        rd(4'd0,  R128_0,  M_ALL, 71, 1'b0);

`ifdef AES_KEYSCHED_INV_EN
        inv_rk = 1'b1;
        rd(4'd0,  R128_0,  M_ALL, 80, 1'b0);
        rd(4'd10, R128_10, M_ALL, 81, 1'b0);
        rd(4'd5,  R128_5,  M_ALL, 82, 1'b1);
        inv_rk = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_reads_left", 128'(q_val.size()), 128'h0);
        chk("sb_done_left", 128'(q_done.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
